// File: rtl/game_state_regfile.sv
// Processor register file that also holds the Tetris side state: current/next piece,
// LFSR piece generator, score with level multiplier and level counter.
module game_state_regfile #(
    parameter int          DATA_W          = 32,
    parameter int          ADDR_W          = 5,
    parameter int          NUM_SHAPES      = 7,
    parameter int          NUM_ROT         = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          LINES_PER_LEVEL = 10,
    parameter int          MAX_LEVEL       = 15,
    parameter int          SHAPE_ADDR      = 1,
    parameter int          SCORE_ADDR      = 3,
    parameter int          LEVEL_ADDR      = 11
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    input  logic [DATA_W-1:0] data_writeReg,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              rotate,
    input  logic              piece_lock,
    input  logic              clear_valid,
    input  logic [2:0]        lines_cleared,
    input  logic              start_over,
    output logic [7:0]        shape_out,
    output logic [3:0]        next_shape_out,
    output logic [DATA_W-1:0] score,
    output logic [3:0]        level
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ROT_W    = 2;
    localparam int LC_W     = $clog2(LINES_PER_LEVEL + 5);
    localparam int SUM_W    = ((DATA_W > 16) ? DATA_W : 16) + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [10:0] line_points(input logic [2:0] n);
        case (n)
            3'd1:    line_points = 11'd40;
            3'd2:    line_points = 11'd100;
            3'd3:    line_points = 11'd300;
            3'd4:    line_points = 11'd1200;
            default: line_points = 11'd0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] gp,
        input logic [DATA_W-1:0] shape_word,
        input logic [DATA_W-1:0] score_word,
        input logic [DATA_W-1:0] level_word
    );
        if (a == '0)                       read_mux = '0;
        else if (a == ADDR_W'(SHAPE_ADDR)) read_mux = shape_word;
        else if (a == ADDR_W'(SCORE_ADDR)) read_mux = score_word;
        else if (a == ADDR_W'(LEVEL_ADDR)) read_mux = level_word;
        else                               read_mux = gp;
    endfunction

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [15:0]       r_lfsr;
    logic [3:0]        r_base;
    logic [3:0]        r_next;
    logic [ROT_W-1:0]  r_rot;
    logic [DATA_W-1:0] r_score;
    logic [3:0]        r_level;
    logic [LC_W-1:0]   r_line_cnt;

    logic              w_wr_ok;
    logic [3:0]        w_lfsr_shape;
    logic [ROT_W-1:0]  w_rot_inc;
    logic [7:0]        w_shape;
    logic [DATA_W-1:0] w_shape_word;
    logic [DATA_W-1:0] w_level_word;
    logic              w_clear_ok;
    logic [15:0]       w_award;
    logic [SUM_W-1:0]  w_score_sum;
    logic [DATA_W-1:0] w_score_nxt;
    logic [LC_W-1:0]   w_lc_sum;
    logic [LC_W-1:0]   w_lc_nxt;
    logic [3:0]        w_level_nxt;

    assign w_wr_ok      = ctrl_writeEnable
                       && (ctrl_writeReg != '0)
                       && (ctrl_writeReg != ADDR_W'(SHAPE_ADDR))
                       && (ctrl_writeReg != ADDR_W'(SCORE_ADDR))
                       && (ctrl_writeReg != ADDR_W'(LEVEL_ADDR));
    assign w_lfsr_shape = 4'(r_lfsr % 16'(NUM_SHAPES));
    assign w_shape      = (8'(r_base) * 8'(NUM_ROT)) + 8'(r_rot);
    assign w_shape_word = DATA_W'(w_shape);
    assign w_level_word = DATA_W'({r_next, r_level});

    assign data_readRegA  = read_mux(ctrl_readRegA, r_regs[ctrl_readRegA],
                                     w_shape_word, r_score, w_level_word);
    assign data_readRegB  = read_mux(ctrl_readRegB, r_regs[ctrl_readRegB],
                                     w_shape_word, r_score, w_level_word);
    assign shape_out      = w_shape;
    assign next_shape_out = r_next;
    assign score          = r_score;
    assign level          = r_level;

    // Rotation increment; the compare also covers NUM_ROT == 1 (stays at 0).
    always_comb begin
        if (r_rot == ROT_W'(NUM_ROT - 1)) begin
            w_rot_inc = '0;
        end else begin
            w_rot_inc = r_rot + ROT_W'(1);
        end
    end

    // Score award uses the level before any level-up caused by this same clear.
    always_comb begin
        w_clear_ok  = clear_valid && (lines_cleared >= 3'd1) && (lines_cleared <= 3'd4);
        w_award     = 16'(line_points(lines_cleared)) * (16'(r_level) + 16'd1);
        w_score_sum = SUM_W'(r_score) + SUM_W'(w_award);
        if (w_score_sum > SUM_W'({DATA_W{1'b1}})) begin
            w_score_nxt = '1;
        end else begin
            w_score_nxt = w_score_sum[DATA_W-1:0];
        end
        w_lc_sum = r_line_cnt + LC_W'(lines_cleared);
        if (w_lc_sum >= LC_W'(LINES_PER_LEVEL)) begin
            w_lc_nxt = w_lc_sum - LC_W'(LINES_PER_LEVEL);
            if (r_level < 4'(MAX_LEVEL)) begin
                w_level_nxt = r_level + 4'd1;
            end else begin
                w_level_nxt = r_level;
            end
        end else begin
            w_lc_nxt    = w_lc_sum;
            w_level_nxt = r_level;
        end
    end

    // General-purpose register array.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Free-running piece generator; a game restart deliberately leaves it alone.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    // Piece, score and level state: restart beats lock beats rotate.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_base     <= 4'd0;
            r_rot      <= '0;
            r_next     <= 4'd1;
            r_score    <= '0;
            r_level    <= 4'd0;
            r_line_cnt <= '0;
        end else if (start_over) begin
            r_base     <= r_next;
            r_rot      <= '0;
            r_next     <= w_lfsr_shape;
            r_score    <= '0;
            r_level    <= 4'd0;
            r_line_cnt <= '0;
        end else begin
            if (piece_lock) begin
                r_base <= r_next;
                r_rot  <= '0;
                r_next <= w_lfsr_shape;
            end else if (rotate) begin
                r_rot <= w_rot_inc;
            end else begin
                r_rot <= r_rot;
            end
            if (w_clear_ok) begin
                r_score    <= w_score_nxt;
                r_line_cnt <= w_lc_nxt;
                r_level    <= w_level_nxt;
            end else begin
                r_score <= r_score;
            end
        end
    end

endmodule

// File: tb/tb_game_state_regfile.sv
// Directed-vector bench for game_state_regfile; a second narrow-score instance
// exercises score saturation.
`timescale 1ns/1ps
module tb_game_state_regfile;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic        rotate, piece_lock, clear_valid, start_over;
    logic [2:0]  lines_cleared;
    logic [7:0]  shape_out;
    logic [3:0]  next_shape_out;
    logic [31:0] score;
    logic [3:0]  level;

    logic [8:0]  s_readA, s_readB, s_score;
    logic [7:0]  s_shape;
    logic [3:0]  s_next, s_level;

    int n_vec = 0;
    int n_bad = 0;
    int e_base, e_next, e_rot;
    logic [15:0] m_lfsr;

    int t1_sc [5] = '{1200, 2400, 3600, 6000, 8400};
    int t1_lv [5] = '{0, 0, 1, 1, 2};
    int t4_n  [5] = '{4, 2, 2, 2, 1};
    int t4_sc [5] = '{1200, 1300, 1400, 1500, 1580};
    int t4_lv [5] = '{0, 0, 0, 1, 1};

    game_state_regfile dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .rotate(rotate), .piece_lock(piece_lock), .clear_valid(clear_valid),
        .lines_cleared(lines_cleared), .start_over(start_over), .shape_out(shape_out),
        .next_shape_out(next_shape_out), .score(score), .level(level)
    );

    game_state_regfile #(.DATA_W(9)) dut_small (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg[8:0]), .data_readRegA(s_readA), .data_readRegB(s_readB),
        .rotate(rotate), .piece_lock(piece_lock), .clear_valid(clear_valid),
        .lines_cleared(lines_cleared), .start_over(start_over), .shape_out(s_shape),
        .next_shape_out(s_next), .score(s_score), .level(s_level)
    );

    always #5 clock = ~clock;

    // Reference Galois LFSR, x^16+x^14+x^13+x^11+1
    always @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) m_lfsr <= SEED;
        else            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic cycle();
        @(posedge clock);
        #1;
        rotate = 1'b0; piece_lock = 1'b0; clear_valid = 1'b0; start_over = 1'b0;
        ctrl_writeEnable = 1'b0; lines_cleared = 3'd0;
    endtask

    task automatic do_reset();
        ctrl_reset = 1'b1;
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        e_base = 0; e_next = 1; e_rot = 0;
    endtask

    task automatic clear(input int n);
        clear_valid = 1'b1; lines_cleared = 3'(n);
        cycle();
    endtask

    task automatic test_reset();
        #2; ctrl_reset = 1'b1; ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd11;
        #1;
        n_vec++; if (shape_out !== 8'd0) begin n_bad++; $display("FAIL rst_shape: got %0d want 0", shape_out); end
        n_vec++; if (next_shape_out !== 4'd1) begin n_bad++; $display("FAIL rst_next: got %0d want 1", next_shape_out); end
        n_vec++; if (score !== 32'd0 || level !== 4'd0) begin n_bad++; $display("FAIL rst_score_level: got %0d/%0d want 0/0", score, level); end
        n_vec++; if (data_readRegA !== 32'd0) begin n_bad++; $display("FAIL rst_reg5: got %h want 0", data_readRegA); end
        n_vec++; if (data_readRegB !== 32'h10) begin n_bad++; $display("FAIL rst_levelreg: got %h want 10", data_readRegB); end
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        e_base = 0; e_next = 1; e_rot = 0;
    endtask

    task automatic test_reset_midgame();
        for (int i = 0; i < 5; i++) begin
            clear(4);
            n_vec++;
            if (score !== 32'(t1_sc[i]) || level !== 4'(t1_lv[i])) begin
                n_bad++; $display("FAIL midgame_clear%0d: got %0d/%0d want %0d/%0d", i, score, level, t1_sc[i], t1_lv[i]);
            end
        end
        #2; ctrl_reset = 1'b1;
        #1;
        n_vec++; if (score !== 32'd0 || level !== 4'd0) begin n_bad++; $display("FAIL async_rst_score: got %0d/%0d want 0/0", score, level); end
        n_vec++; if (shape_out !== 8'd0 || next_shape_out !== 4'd1) begin n_bad++; $display("FAIL async_rst_shape: got %0d/%0d want 0/1", shape_out, next_shape_out); end
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        // Seed restart: locks see 0xACE1, 0xE270, 0x7138 -> mod 7 = 3, 1, 4
        piece_lock = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'd4 || next_shape_out !== 4'd3) begin n_bad++; $display("FAIL seed_lock1: got %0d/%0d want 4/3", shape_out, next_shape_out); end
        piece_lock = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'd12 || next_shape_out !== 4'd1) begin n_bad++; $display("FAIL seed_lock2: got %0d/%0d want 12/1", shape_out, next_shape_out); end
        piece_lock = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'd4 || next_shape_out !== 4'd4) begin n_bad++; $display("FAIL seed_lock3: got %0d/%0d want 4/4", shape_out, next_shape_out); end
        e_base = 1; e_next = 4; e_rot = 0;
    endtask

    task automatic test_regfile();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEAD; ctrl_readRegA = 5'd5;
        #1;
        n_vec++; if (data_readRegA !== 32'd0) begin n_bad++; $display("FAIL no_bypass: got %h want 0", data_readRegA); end
        cycle();
        n_vec++; if (data_readRegA !== 32'hDEAD) begin n_bad++; $display("FAIL wr_reg5: got %h want dead", data_readRegA); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hBEEF; ctrl_readRegA = 5'd0;
        cycle();
        n_vec++; if (data_readRegA !== 32'd0) begin n_bad++; $display("FAIL wr_reg0: got %h want 0", data_readRegA); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h1234; ctrl_readRegB = 5'd3;
        cycle();
        n_vec++; if (data_readRegB !== 32'd0) begin n_bad++; $display("FAIL wr_score_addr: got %h want 0", data_readRegB); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd11; data_writeReg = 32'hFFFF; ctrl_readRegB = 5'd11;
        cycle();
        n_vec++; if (data_readRegB !== 32'h40) begin n_bad++; $display("FAIL wr_level_addr: got %h want 40", data_readRegB); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'h77; ctrl_readRegA = 5'd1;
        cycle();
        n_vec++; if (data_readRegA !== 32'd4) begin n_bad++; $display("FAIL wr_shape_addr: got %h want 4", data_readRegA); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd31; data_writeReg = 32'hA5A5_0001; ctrl_readRegA = 5'd31; ctrl_readRegB = 5'd5;
        cycle();
        n_vec++; if (data_readRegA !== 32'hA5A5_0001 || data_readRegB !== 32'hDEAD) begin n_bad++; $display("FAIL wr_reg31: got %h/%h want a5a50001/dead", data_readRegA, data_readRegB); end
    endtask

    task automatic test_rotate_lock();
        int guard = 0;
        while (e_next != 2 && guard < 200) begin
            e_base = e_next; e_next = int'(m_lfsr % 16'd7);
            piece_lock = 1'b1; cycle(); guard++;
        end
        n_vec++; if (guard >= 200) begin n_bad++; $display("FAIL find_shape2: got no next=2 within %0d locks, want one", guard); end
        e_base = e_next; e_next = int'(m_lfsr % 16'd7);
        piece_lock = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'(e_base * 4) || next_shape_out !== 4'(e_next)) begin n_bad++; $display("FAIL lock_base2: got %0d/%0d want %0d/%0d", shape_out, next_shape_out, e_base * 4, e_next); end
        repeat (3) begin rotate = 1'b1; cycle(); cycle(); end
        n_vec++; if (shape_out !== 8'd11) begin n_bad++; $display("FAIL rot3: got %0d want 11", shape_out); end
        rotate = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'd8) begin n_bad++; $display("FAIL rot_wrap: got %0d want 8", shape_out); end
        rotate = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'd9) begin n_bad++; $display("FAIL rot1: got %0d want 9", shape_out); end
        e_base = e_next; e_next = int'(m_lfsr % 16'd7);
        piece_lock = 1'b1; rotate = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'(e_base * 4) || next_shape_out !== 4'(e_next)) begin n_bad++; $display("FAIL lock_rot: got %0d/%0d want %0d/%0d", shape_out, next_shape_out, e_base * 4, e_next); end
    endtask

    task automatic test_back_to_back();
        rotate = 1'b1;
        repeat (5) @(posedge clock);
        #1; rotate = 1'b0;
        n_vec++; if (shape_out !== 8'(e_base * 4 + 1)) begin n_bad++; $display("FAIL held_rotate: got %0d want %0d", shape_out, e_base * 4 + 1); end
    endtask

    task automatic test_score();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clear(t4_n[i]);
            n_vec++;
            if (score !== 32'(t4_sc[i]) || level !== 4'(t4_lv[i])) begin
                n_bad++; $display("FAIL score_step%0d: got %0d/%0d want %0d/%0d", i, score, level, t4_sc[i], t4_lv[i]);
            end
        end
        clear(0); clear(5); clear(7);
        ctrl_readRegA = 5'd11; ctrl_readRegB = 5'd3; #1;
        n_vec++; if (data_readRegB !== 32'd1580) begin n_bad++; $display("FAIL bad_n_ignored: got %0d want 1580", data_readRegB); end
        n_vec++; if (data_readRegA !== 32'h11) begin n_bad++; $display("FAIL level_word: got %h want 11", data_readRegA); end
    endtask

    task automatic test_saturation();
        do_reset();
        clear(2); clear(2); clear(2);
        n_vec++; if (s_score !== 9'd300 || score !== 32'd300) begin n_bad++; $display("FAIL presat: got %0d/%0d want 300/300", s_score, score); end
        clear(3);
        n_vec++; if (s_score !== 9'd511) begin n_bad++; $display("FAIL sat_small: got %0d want 511", s_score); end
        n_vec++; if (score !== 32'd600) begin n_bad++; $display("FAIL nosat_wide: got %0d want 600", score); end
        clear(1);
        n_vec++; if (s_score !== 9'd511 || score !== 32'd640 || level !== 4'd1) begin n_bad++; $display("FAIL sat_hold: got %0d/%0d/%0d want 511/640/1", s_score, score, level); end
        do_reset();
        repeat (45) clear(4);
        n_vec++; if (level !== 4'd15) begin n_bad++; $display("FAIL level_sat: got %0d want 15", level); end
    endtask

    task automatic test_start_over();
        do_reset();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hCAFE; cycle();
        clear(4); clear(4); clear(4);
        n_vec++; if (score !== 32'd3600 || level !== 4'd1) begin n_bad++; $display("FAIL so_pre: got %0d/%0d want 3600/1", score, level); end
        e_base = e_next; e_next = int'(m_lfsr % 16'd7);
        start_over = 1'b1; clear_valid = 1'b1; lines_cleared = 3'd4; piece_lock = 1'b1; rotate = 1'b1;
        cycle();
        n_vec++; if (score !== 32'd0 || level !== 4'd0) begin n_bad++; $display("FAIL so_score: got %0d/%0d want 0/0", score, level); end
        n_vec++; if (shape_out !== 8'(e_base * 4) || next_shape_out !== 4'(e_next)) begin n_bad++; $display("FAIL so_shape: got %0d/%0d want %0d/%0d", shape_out, next_shape_out, e_base * 4, e_next); end
        ctrl_readRegA = 5'd5; #1;
        n_vec++; if (data_readRegA !== 32'hCAFE) begin n_bad++; $display("FAIL so_gp_kept: got %h want cafe", data_readRegA); end
        clear(4); clear(4);
        n_vec++; if (score !== 32'd2400 || level !== 4'd0) begin n_bad++; $display("FAIL so_linecnt: got %0d/%0d want 2400/0", score, level); end
        clear(2);
        n_vec++; if (score !== 32'd2500 || level !== 4'd1) begin n_bad++; $display("FAIL so_levelup: got %0d/%0d want 2500/1", score, level); end
        e_base = e_next; e_next = int'(m_lfsr % 16'd7);
        piece_lock = 1'b1; cycle();
        n_vec++; if (shape_out !== 8'(e_base * 4) || next_shape_out !== 4'(e_next)) begin n_bad++; $display("FAIL so_lfsr_cont: got %0d/%0d want %0d/%0d", shape_out, next_shape_out, e_base * 4, e_next); end
    endtask

    initial begin
        ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0; ctrl_writeReg = 5'd0;
        ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0; data_writeReg = 32'd0;
        rotate = 1'b0; piece_lock = 1'b0; clear_valid = 1'b0; start_over = 1'b0;
        lines_cleared = 3'd0;
        e_base = 0; e_next = 1; e_rot = 0;
        test_reset();
        test_reset_midgame();
        test_regfile();
        test_rotate_lock();
        test_back_to_back();
        test_score();
        test_saturation();
        test_start_over();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
